cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter: COUNT_W, 8, width of retired-instruction counter.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately, independent of clk.
REQ-004 run  input  1  level; 1 = execute instructions continuously.
REQ-005 step  input  1  single-cycle pulse; requests execution of exactly one instruction.
REQ-006 resume  input  1  single-cycle pulse; leaves HALT.
REQ-007 halt_op  input  1  decoded flag from control unit; current instruction is HALT.
REQ-008 cu_reg_we  input  1  register write enable from control unit.
REQ-009 ir_load  output  1  load instruction register from instruction memory.
REQ-010 pc_en  output  1  advance program counter by one.
REQ-011 reg_we  output  1  gated register-bank write enable.
REQ-012 state  output  3  current FSM state encoding.
REQ-013 busy  output  1  1 in any state other than IDLE and HALT.
REQ-014 halted  output  1  1 only in HALT.
REQ-015 instr_count  output  COUNT_W  number of retired instructions.

Function
REQ-016 States and encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5; codes 6-7 return to IDLE next cycle.
REQ-017 IDLE: run=1 -> FETCH with single-step flag cleared; else step=1 -> FETCH with single-step flag set; else stay.
REQ-018 IDLE with run and step both 1: run wins, single-step flag cleared.
REQ-019 FETCH -> DECODE unconditionally; ir_load=1 for exactly this cycle.
REQ-020 DECODE: halt_op=1 -> HALT; else -> EXECUTE.
REQ-021 EXECUTE -> WRITEBACK unconditionally; no strobes asserted.
REQ-022 WRITEBACK: pc_en=1; reg_we=cu_reg_we; instr_count increments by 1.
REQ-023 WRITEBACK exit: single-step flag set or run=0 -> IDLE; else -> FETCH.
REQ-024 Non-halt instruction latency: 4 cycles FETCH-to-WRITEBACK inclusive; continuous-run throughput one instruction per 4 cycles.
REQ-025 HALT instruction: PC not advanced, reg_we never asserted, instr_count unchanged.
REQ-026 HALT: resume=1 -> IDLE; run and step ignored in HALT.
REQ-027 step pulses outside IDLE, and resume pulses outside HALT, ignored; not queued.
REQ-028 run deassert mid-instruction: instruction completes through WRITEBACK, then IDLE.
REQ-029 instr_count wraps from 2^COUNT_W-1 to 0, no flag.
REQ-030 ir_load, pc_en, busy, halted, state decoded solely from state register (Moore, glitch-free); reg_we = (state==WRITEBACK) AND cu_reg_we.
REQ-031 At most one of ir_load, pc_en asserted in any cycle.

Reset
REQ-032 While reset=0: state=IDLE, single-step flag=0, instr_count=0, ir_load=pc_en=reg_we=busy=halted=0.
REQ-033 Reset asserted in any state, including mid-WRITEBACK, aborts immediately; no pc_en or reg_we pulse after assertion.
REQ-034 After release, first transition is at earliest on the first rising clk edge with reset=1.

Verification
REQ-035 Reset release, run=1, halt_op=0, cu_reg_we=1 for 12 cycles -> states 1,2,3,4 repeat; pc_en pulses at cycles 4,8,12; instr_count=3.
REQ-036 IDLE, run=0, one step pulse -> ir_load one cycle, single pc_en and reg_we in cycle 4, back in IDLE; instr_count=1; later step with no run repeats exactly once.
REQ-037 run=1, halt_op=1 in DECODE -> state=5, halted=1, busy=0, no pc_en/reg_we; run held 1 for 10 cycles stays HALT; resume pulse -> IDLE then FETCH.
REQ-038 COUNT_W=8, instr_count preloaded to 255 via 255 retired instructions -> next WRITEBACK gives 0.
REQ-039 reset=0 asserted asynchronously mid-EXECUTE, between clock edges -> all outputs 0, state=0 before next edge; cu_reg_we=1 produces no reg_we.
REQ-040 run and step both 1 in IDLE, run dropped in EXECUTE -> instruction completes, IDLE, no second fetch.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: steps the CPU through FETCH/DECODE/EXECUTE/WRITEBACK,
// with run/step control, a HALT trap and a wrapping retired-instruction counter.
module cpu_sequencer #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic               resume,
  input  logic               halt_op,
  input  logic               cu_reg_we,
  output logic               ir_load,
  output logic               pc_en,
  output logic               reg_we,
  output logic [2:0]         state,
  output logic               busy,
  output logic               halted,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  // Plain 3-bit register so the unused codes 6-7 stay representable.
  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic               r_single;
  logic               w_single_nxt;
  logic [COUNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_single <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_single <= w_single_nxt;
      if (r_state == S_WRITEBACK)
        r_count <= r_count + COUNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt  = S_IDLE;
    w_single_nxt = r_single;
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_state_nxt  = S_FETCH;
          w_single_nxt = 1'b0;
        end else if (step) begin
          w_state_nxt  = S_FETCH;
          w_single_nxt = 1'b1;
        end else begin
          w_state_nxt  = S_IDLE;
        end
      end
      S_FETCH:     w_state_nxt = S_DECODE;
      S_DECODE:    w_state_nxt = halt_op ? S_HALT : S_EXECUTE;
      S_EXECUTE:   w_state_nxt = S_WRITEBACK;
      S_WRITEBACK: w_state_nxt = (r_single || !run) ? S_IDLE : S_FETCH;
      S_HALT:      w_state_nxt = resume ? S_IDLE : S_HALT;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Moore strobes; only reg_we additionally qualifies on the control unit.
  assign ir_load     = (r_state == S_FETCH);
  assign pc_en       = (r_state == S_WRITEBACK);
  assign reg_we      = (r_state == S_WRITEBACK) && cu_reg_we;
  assign busy        = (r_state >= S_FETCH) && (r_state <= S_WRITEBACK);
  assign halted      = (r_state == S_HALT);
  assign state       = r_state;
  assign instr_count = r_count;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: expected outputs are queued as each
// stimulus step is driven and checked once the clock edge has taken effect.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run, step, resume, halt_op, cu_reg_we;
  logic       ir_load, pc_en, reg_we, busy, halted;
  logic [2:0] state;
  logic [7:0] instr_count;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  cpu_sequencer #(.COUNT_W(8)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .resume(resume),
    .halt_op(halt_op), .cu_reg_we(cu_reg_we), .ir_load(ir_load),
    .pc_en(pc_en), .reg_we(reg_we), .state(state), .busy(busy),
    .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Expected output vector derived from the state definitions.
  function automatic logic [15:0] mk(input logic [2:0] st, input logic we,
                                     input logic [7:0] cnt);
    logic ir, pc, bz, hl;
    ir = (st == 3'd1);
    pc = (st == 3'd4);
    bz = (st == 3'd1) || (st == 3'd2) || (st == 3'd3) || (st == 3'd4);
    hl = (st == 3'd5);
    return {st, ir, pc, we, bz, hl, cnt};
  endfunction

  task automatic check_pop();
    exp_t        e;
    logic [15:0] obs;
    e   = q.pop_front();
    obs = {state, ir_load, pc_en, reg_we, busy, halted, instr_count};
    n_total++;
    assert (obs === e.v) n_pass++;
    else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
  endtask

  task automatic exp_now(input string tag, input logic [2:0] st,
                         input logic we, input logic [7:0] cnt);
    q.push_back('{tag, mk(st, we, cnt)});
    check_pop();
  endtask

  task automatic exp_next(input string tag, input logic [2:0] st,
                          input logic we, input logic [7:0] cnt);
    q.push_back('{tag, mk(st, we, cnt)});
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; step = 1'b0; resume = 1'b0;
    halt_op = 1'b0; cu_reg_we = 1'b0;
    #2;
    exp_now("reset_state", 3'd0, 1'b0, 8'd0);
    exp_next("reset_held", 3'd0, 1'b0, 8'd0);

    // Continuous run: three instructions, then run drops during WRITEBACK.
    reset = 1'b1; run = 1'b1; cu_reg_we = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_next("run_fetch", 3'd1, 1'b0, 8'(k));
      exp_next("run_decode", 3'd2, 1'b0, 8'(k));
      exp_next("run_exec", 3'd3, 1'b0, 8'(k));
      exp_next("run_wb", 3'd4, 1'b1, 8'(k));
    end
    run = 1'b0;
    exp_next("run_stop_idle", 3'd0, 1'b0, 8'd3);

    // Single step; a second step pulse during FETCH must be ignored.
    step = 1'b1;
    exp_next("step_fetch", 3'd1, 1'b0, 8'd3);
    step = 1'b0;
    exp_next("step_decode", 3'd2, 1'b0, 8'd3);
    exp_next("step_exec", 3'd3, 1'b0, 8'd3);
    exp_next("step_wb", 3'd4, 1'b1, 8'd3);
    exp_next("step_idle", 3'd0, 1'b0, 8'd4);
    exp_next("step_idle_stay", 3'd0, 1'b0, 8'd4);
    step = 1'b1; cu_reg_we = 1'b0;
    exp_next("step2_fetch", 3'd1, 1'b0, 8'd4);
    exp_next("step2_ignored", 3'd2, 1'b0, 8'd4);
    step = 1'b0;
    exp_next("step2_exec", 3'd3, 1'b0, 8'd4);
    exp_next("step2_wb_nowe", 3'd4, 1'b0, 8'd4);
    exp_next("step2_idle", 3'd0, 1'b0, 8'd5);
    exp_next("step2_idle_stay", 3'd0, 1'b0, 8'd5);

    // HALT trap: run and step are ignored until resume.
    run = 1'b1; halt_op = 1'b1; cu_reg_we = 1'b1;
    exp_next("halt_fetch", 3'd1, 1'b0, 8'd5);
    exp_next("halt_decode", 3'd2, 1'b0, 8'd5);
    exp_next("halt_enter", 3'd5, 1'b0, 8'd5);
    step = 1'b1;
    for (int k = 0; k < 10; k++) exp_next("halt_hold", 3'd5, 1'b0, 8'd5);
    step = 1'b0; resume = 1'b1; halt_op = 1'b0;
    exp_next("halt_resume_idle", 3'd0, 1'b0, 8'd5);
    resume = 1'b0;

    // run and step together: run wins; run dropped in EXECUTE ends the run.
    step = 1'b1;
    exp_next("both_fetch", 3'd1, 1'b0, 8'd5);
    step = 1'b0;
    exp_next("both_decode", 3'd2, 1'b0, 8'd5);
    exp_next("both_exec", 3'd3, 1'b0, 8'd5);
    run = 1'b0;
    exp_next("both_wb", 3'd4, 1'b1, 8'd5);
    exp_next("both_idle", 3'd0, 1'b0, 8'd6);
    resume = 1'b1;
    exp_next("resume_ignored", 3'd0, 1'b0, 8'd6);
    resume = 1'b0;

    // Asynchronous reset mid-EXECUTE, between clock edges.
    run = 1'b1;
    exp_next("ar_fetch", 3'd1, 1'b0, 8'd6);
    exp_next("ar_decode", 3'd2, 1'b0, 8'd6);
    exp_next("ar_exec", 3'd3, 1'b0, 8'd6);
    #2 reset = 1'b0;
    #1;
    exp_now("ar_async_clear", 3'd0, 1'b0, 8'd0);
    exp_next("ar_held", 3'd0, 1'b0, 8'd0);
    reset = 1'b1;

    // Counter wrap after 256 retired instructions.
    for (int k = 0; k < 256; k++) begin
      exp_next("wrap_fetch", 3'd1, 1'b0, 8'(k));
      exp_next("wrap_decode", 3'd2, 1'b0, 8'(k));
      exp_next("wrap_exec", 3'd3, 1'b0, 8'(k));
      exp_next("wrap_wb", 3'd4, 1'b1, 8'(k));
    end
    exp_next("wrap_zero", 3'd1, 1'b0, 8'd0);
    exp_next("wrap_decode2", 3'd2, 1'b0, 8'd0);
    exp_next("wrap_exec2", 3'd3, 1'b0, 8'd0);
    exp_next("wrap_wb2", 3'd4, 1'b1, 8'd0);

    // Asynchronous reset in the middle of WRITEBACK.
    #2 reset = 1'b0;
    #1;
    exp_now("wb_async_clear", 3'd0, 1'b0, 8'd0);
    exp_next("wb_reset_held", 3'd0, 1'b0, 8'd0);
    run = 1'b0;
    reset = 1'b1;
    exp_next("final_idle", 3'd0, 1'b0, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
